// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared fetch-pipeline types and constants
package imem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Word-aligned and inside a store of 2**aw words.
    function automatic logic word_ok(input logic [31:0] a, input int aw);
        return (a[1:0] == 2'b00) && ((a >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction store, one synchronous write port and one asynchronous read port
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // No reset: program contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder with flush and program load
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] instruction,
    output logic        ready,
    output logic        stall,
    output logic        addr_err
);

    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    imem_state_t state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] latched_addr, latched_addr_nx;
    logic [31:0] rdata;
    logic        fetch_ok;
    logic        mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            latched_addr <= 32'd0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            latched_addr <= latched_addr_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        latched_addr_nx = latched_addr;
        ready           = 1'b0;
        case (state)
            IDLE: begin
                if (req && !flush) begin
                    latched_addr_nx = addr;
                    cnt_nx          = LOAD;
                    state_nx        = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                ready    = !flush;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fetch_ok    = word_ok(latched_addr, AW);
    assign instruction = (ready && fetch_ok) ? rdata : NOP;
    assign addr_err    = ready && !fetch_ok;
    assign stall       = req && !ready;

    // Program loads only land while no fetch is in flight.
    assign mem_we = wr_en && (state == IDLE) && word_ok(wr_addr, AW);

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr[AW+1:2]),
        .wdata (wr_data),
        .raddr (latched_addr[AW+1:2]),
        .rdata (rdata)
    );

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the instruction-store size in 32-bit words (power of two).
REQ-002 Parameter LATENCY, default 3, SHALL set the cycles from request acceptance to response (legal range 1..15).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Port req  input  1  SHALL be the fetch request from the fetch stage, held until ready.
REQ-006 Port addr  input  32  SHALL be the byte address (pc) of the requested instruction.
REQ-007 Port flush  input  1  SHALL cancel an outstanding fetch (branch taken).
REQ-008 Port wr_en  input  1  SHALL be the program-load write strobe.
REQ-009 Port wr_addr  input  32  SHALL be the program-load byte address.
REQ-010 Port wr_data  input  32  SHALL be the program-load word.
REQ-011 Port instruction  output  32  SHALL be the fetched instruction word, valid when ready=1.
REQ-012 Port ready  output  1  SHALL pulse high for one cycle when a response is valid.
REQ-013 Port stall  output  1  SHALL be the freeze request to the fetch stage: req & ~ready (combinational).
REQ-014 Port addr_err  output  1  SHALL flag a misaligned or out-of-range fetch, valid with ready.

Function
REQ-015 FSM states IDLE, WAIT, RESP SHALL be used; encoding is free.
REQ-016 IDLE: req=1 and flush=0 SHALL latch addr and load the counter with LATENCY-1, then go to WAIT, or directly to RESP if LATENCY=1.
REQ-017 WAIT: the counter SHALL decrement each cycle; at zero, the state SHALL go to RESP.
REQ-018 RESP: ready=1 for exactly one cycle, with instruction=mem[latched_addr[log2(DEPTH)+1:2]]; the state SHALL then return to IDLE.
REQ-019 Request-to-ready latency SHALL be exactly LATENCY+1 cycles from the acceptance edge; back-to-back requests SHALL pay one IDLE cycle each.
REQ-020 Changes to addr while in WAIT SHALL be ignored; the latched address governs the response.
REQ-021 flush=1 in WAIT SHALL abort to IDLE with no ready pulse; flush in IDLE SHALL block acceptance that cycle; flush in RESP SHALL suppress ready and return to IDLE.
REQ-022 latched_addr[1:0]!=0 or word index >= DEPTH SHALL give instruction=32'h0 (NOP) and addr_err=1 with ready.
REQ-023 Outside a ready cycle, instruction and addr_err SHALL be 0.
REQ-024 A write with wr_en=1 SHALL store wr_data at word wr_addr[log2(DEPTH)+1:2] on the same edge, only when in IDLE and wr_addr is aligned and in range; otherwise it SHALL be dropped.
REQ-025 A write and a req in the same IDLE cycle SHALL both take effect; a later response to the written word SHALL return the new data.

Reset
REQ-026 rst=1 SHALL force IDLE, counter=0, latched address=0, ready=0, addr_err=0 and instruction=0 on the next edge, including mid-WAIT, with no ready pulse.
REQ-027 Reset SHALL NOT clear memory contents; stall SHALL follow req while no response is pending after reset.

Structure
REQ-028 The FSM state typedef and the NOP constant (32'h0) SHALL live in the shared pipeline package.
REQ-029 The storage array SHALL be one sub-module, imem_array (1 sync write port, 1 async read port); the FSM/counter SHALL stay in imem_responder.

Verification
REQ-030 Load 0x11111111 at addr 0x8; req with addr=0x8 -> ready one cycle on the 4th edge after acceptance, instruction=0x11111111, addr_err=0, stall high for the 3 prior cycles.
REQ-031 req with addr=0x6 -> ready with instruction=0x0, addr_err=1.
REQ-032 req with addr=0x400 (DEPTH=256) -> instruction=0x0, addr_err=1.
REQ-033 req with addr=0x8, flush pulsed 1 cycle later -> no ready; a new req with addr=0xC is accepted the next IDLE cycle and responds normally.
REQ-034 rst asserted during WAIT -> next cycle in IDLE, ready=0; a later req to 0x8 still returns 0x11111111.
REQ-035 With LATENCY=1, req held over consecutive fetches -> ready every 2nd cycle; wr_en during WAIT -> write dropped, memory unchanged.
